// File: rtl/external_bus_arbiter_if.sv
// External bus between the arbiter (master side) and the attached slave.
// The arbiter drives address/control/write data; the slave answers with
// acknowledge and read data.
interface external_bus_arbiter_if;
    logic [19:0] address;
    logic        bus_enable;
    logic [1:0]  byte_enable;
    logic        rw;
    logic [15:0] write_data;
    logic        acknowledge;
    logic [15:0] read_data;

    modport master (
        output address,
        output bus_enable,
        output byte_enable,
        output rw,
        output write_data,
        input  acknowledge,
        input  read_data
    );

    modport slave (
        input  address,
        input  bus_enable,
        input  byte_enable,
        input  rw,
        input  write_data,
        output acknowledge,
        output read_data
    );
endinterface

// File: rtl/external_bus_arbiter.sv
// Two-master arbiter for a single external bus. Masters are served one
// transaction at a time with round-robin tie breaking; each transaction ends
// on slave acknowledge or after TIMEOUT unacknowledged bus cycles, and is
// always followed by a turnaround cycle with the bus released.
module external_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,

    input  logic                  m0_request,
    input  logic [19:0]           m0_address,
    input  logic [1:0]            m0_byte_enable,
    input  logic                  m0_rw,
    input  logic [15:0]           m0_write_data,
    output logic                  m0_grant,
    output logic                  m0_done,
    output logic                  m0_timeout,
    output logic [15:0]           m0_read_data,

    input  logic                  m1_request,
    input  logic [19:0]           m1_address,
    input  logic [1:0]            m1_byte_enable,
    input  logic                  m1_rw,
    input  logic [15:0]           m1_write_data,
    output logic                  m1_grant,
    output logic                  m1_done,
    output logic                  m1_timeout,
    output logic [15:0]           m1_read_data,

    external_bus_arbiter_if.master bus
);

    // Counter value seen on the last permitted unacknowledged BUS cycle.
    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT - 1);
    localparam logic [15:0] DEAD_DATA  = 16'hDEAD;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        TURN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;        // 1: master 1 was granted last
    logic              owner_q, owner_d;      // master owning the current transaction
    logic [15:0]       count_q, count_d;
    logic [19:0]       address_q, address_d;
    logic              bus_enable_q, bus_enable_d;
    logic [1:0]        byte_enable_q, byte_enable_d;
    logic              rw_q, rw_d;
    logic [15:0]       write_data_q, write_data_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        timeout_q, timeout_d;
    logic [1:0][15:0]  read_data_q, read_data_d;
    logic              winner;

    // Next-state and next-output decode for the arbitration FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        last_d        = last_q;
        owner_d       = owner_q;
        count_d       = count_q;
        address_d     = address_q;
        bus_enable_d  = bus_enable_q;
        byte_enable_d = byte_enable_q;
        rw_d          = rw_q;
        write_data_d  = write_data_q;
        grant_d       = grant_q;
        done_d        = '0;
        timeout_d     = '0;
        read_data_d   = read_data_q;
        winner        = 1'b0;

        unique case (state_q)
            IDLE: begin
                // On a tie the master that did not win last time goes first.
                if (m0_request && m1_request) begin
                    winner = ~last_q;
                end else begin
                    winner = m1_request;
                end

                if (m0_request || m1_request) begin
                    owner_d       = winner;
                    last_d        = winner;
                    count_d       = '0;
                    address_d     = winner ? m1_address     : m0_address;
                    byte_enable_d = winner ? m1_byte_enable : m0_byte_enable;
                    rw_d          = winner ? m1_rw          : m0_rw;
                    write_data_d  = winner ? m1_write_data  : m0_write_data;
                    bus_enable_d  = 1'b1;
                    grant_d       = winner ? 2'b10 : 2'b01;
                    state_d       = BUS;
                end
            end

            BUS: begin
                // Acknowledge takes priority over an expiry in the same cycle.
                if (bus.acknowledge || (count_q == LAST_COUNT)) begin
                    done_d[owner_q]    = 1'b1;
                    timeout_d[owner_q] = ~bus.acknowledge;
                    if (rw_q) begin
                        read_data_d[owner_q] = bus.acknowledge ? bus.read_data : DEAD_DATA;
                    end
                    bus_enable_d = 1'b0;
                    grant_d      = '0;
                    state_d      = TURN;
                end else begin
                    count_d = count_q + 16'd1;
                end
            end

            TURN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered-output update with synchronous active-low reset.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q       <= IDLE;
            last_q        <= 1'b1;
            owner_q       <= 1'b0;
            count_q       <= '0;
            address_q     <= '0;
            bus_enable_q  <= 1'b0;
            byte_enable_q <= '0;
            rw_q          <= 1'b0;
            write_data_q  <= '0;
            grant_q       <= '0;
            done_q        <= '0;
            timeout_q     <= '0;
            read_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            owner_q       <= owner_d;
            count_q       <= count_d;
            address_q     <= address_d;
            bus_enable_q  <= bus_enable_d;
            byte_enable_q <= byte_enable_d;
            rw_q          <= rw_d;
            write_data_q  <= write_data_d;
            grant_q       <= grant_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
            read_data_q   <= read_data_d;
        end
    end

    assign m0_grant        = grant_q[0];
    assign m0_done         = done_q[0];
    assign m0_timeout      = timeout_q[0];
    assign m0_read_data    = read_data_q[0];
    assign m1_grant        = grant_q[1];
    assign m1_done         = done_q[1];
    assign m1_timeout      = timeout_q[1];
    assign m1_read_data    = read_data_q[1];

    assign bus.address     = address_q;
    assign bus.bus_enable  = bus_enable_q;
    assign bus.byte_enable = byte_enable_q;
    assign bus.rw          = rw_q;
    assign bus.write_data  = write_data_q;

endmodule

// File: tb/tb_external_bus_arbiter.sv
// Self-checking bench for external_bus_arbiter: directed scenarios with
// literal expectations, then randomized traffic, all compared every cycle
// against a transaction-level model of the arbiter.
module tb_external_bus_arbiter;

    localparam int TMO = 4;

    logic clk_clk = 1'b0;
    logic reset_reset_n = 1'b0;
    always #5 clk_clk = ~clk_clk;

    logic        req    [2];
    logic [19:0] m_addr [2];
    logic [1:0]  m_be   [2];
    logic        m_rw   [2];
    logic [15:0] m_wd   [2];

    logic        m0_grant, m0_done, m0_timeout;
    logic        m1_grant, m1_done, m1_timeout;
    logic [15:0] m0_read_data, m1_read_data;

    external_bus_arbiter_if bus_if();

    external_bus_arbiter #(.TIMEOUT(TMO)) dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .m0_request     (req[0]),
        .m0_address     (m_addr[0]),
        .m0_byte_enable (m_be[0]),
        .m0_rw          (m_rw[0]),
        .m0_write_data  (m_wd[0]),
        .m0_grant       (m0_grant),
        .m0_done        (m0_done),
        .m0_timeout     (m0_timeout),
        .m0_read_data   (m0_read_data),
        .m1_request     (req[1]),
        .m1_address     (m_addr[1]),
        .m1_byte_enable (m_be[1]),
        .m1_rw          (m_rw[1]),
        .m1_write_data  (m_wd[1]),
        .m1_grant       (m1_grant),
        .m1_done        (m1_done),
        .m1_timeout     (m1_timeout),
        .m1_read_data   (m1_read_data),
        .bus            (bus_if)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A transaction is owned by one master for 'age' bus cycles; after it
    // ends the bus rests one cooldown cycle before arbitration resumes.
    int          own  = -1;
    int          age  = 0;
    int          cool = 0;
    int          last = 1;
    logic [19:0] e_addr = '0;
    logic [1:0]  e_be   = '0;
    logic        e_rw   = 1'b0;
    logic [15:0] e_wd   = '0;
    logic [15:0] e_rd   [2] = '{16'h0, 16'h0};
    bit          e_done [2] = '{1'b0, 1'b0};
    bit          e_to   [2] = '{1'b0, 1'b0};

    always @(posedge clk_clk) begin
        e_done = '{1'b0, 1'b0};
        e_to   = '{1'b0, 1'b0};
        if (!reset_reset_n) begin
            own = -1; age = 0; cool = 0; last = 1;
            e_addr = '0; e_be = '0; e_rw = 1'b0; e_wd = '0;
            e_rd = '{16'h0, 16'h0};
        end else if (own >= 0) begin
            age = age + 1;
            if (bus_if.acknowledge || age == TMO) begin
                e_done[own] = 1'b1;
                e_to[own]   = !bus_if.acknowledge;
                if (e_rw) e_rd[own] = bus_if.acknowledge ? bus_if.read_data : 16'hDEAD;
                own  = -1;
                cool = 1;
            end
        end else if (cool > 0) begin
            cool = cool - 1;
        end else if (req[0] || req[1]) begin
            own    = (req[0] && req[1]) ? 1 - last : (req[1] ? 1 : 0);
            last   = own;
            age    = 0;
            e_addr = m_addr[own];
            e_be   = m_be[own];
            e_rw   = m_rw[own];
            e_wd   = m_wd[own];
        end
    end

    // ---------------- per-cycle comparison ----------------
    bit cmp_en = 1'b0;

    always @(negedge clk_clk) begin
        if (cmp_en) begin
            check("ctrl",
                  {bus_if.bus_enable, m1_grant, m0_grant, m1_done, m0_done, m1_timeout, m0_timeout},
                  {own >= 0, own == 1, own == 0, e_done[1], e_done[0], e_to[1], e_to[0]});
            check("rdata", {m1_read_data, m0_read_data}, {e_rd[1], e_rd[0]});
            if (own >= 0) begin
                check("bus_fields",
                      {bus_if.address, bus_if.byte_enable, bus_if.rw, bus_if.write_data},
                      {e_addr, e_be, e_rw, e_wd});
            end
        end
    end

    // ---------------- stimulus state and monitor ----------------
    int          ack_delay   = -1;
    int          wait_cnt    = 0;
    logic [15:0] slave_value = '0;
    bit          rand_mode   = 1'b0;
    bit          idle_noise  = 1'b0;
    bit          hold [2]    = '{1'b0, 1'b0};

    int          cyc = 0;
    int          be_cycles, first_be_cyc, issue_cyc, ack_cyc, done_cyc, to_cyc;
    int          done_cnt [2];
    int          to_cnt   [2];
    logic [19:0] mon_addr;
    logic [1:0]  mon_be;
    logic        mon_rw;
    logic [15:0] mon_wd;
    logic        be_at_done;
    int          grant_seq [$];
    int          min_gap, cur_gap;
    bit          prev_be, seen_tx;
    bit          done_now  [2];
    bit          grant_now [2];

    task automatic clear_mon();
        be_cycles = 0; first_be_cyc = -1; ack_cyc = -1; done_cyc = -1; to_cyc = -1;
        done_cnt = '{0, 0}; to_cnt = '{0, 0};
        mon_addr = '0; mon_be = '0; mon_rw = 1'b0; mon_wd = '0; be_at_done = 1'b1;
        grant_seq.delete();
        min_gap = 1000; cur_gap = 0; prev_be = bus_if.bus_enable; seen_tx = 1'b0;
    endtask

    task automatic rand_fields(input int n);
        m_addr[n] = 20'($urandom);
        m_be[n]   = 2'($urandom);
        m_rw[n]   = 1'($urandom);
        m_wd[n]   = 16'($urandom);
    endtask

    task automatic issue(input int n, input logic [19:0] a, input logic [1:0] be,
                         input logic rw, input logic [15:0] wd);
        m_addr[n] = a; m_be[n] = be; m_rw[n] = rw; m_wd[n] = wd;
        req[n] = 1'b1;
        issue_cyc = cyc;
    endtask

    task automatic slave_step();
        if (bus_if.bus_enable) begin
            if (wait_cnt == ack_delay) begin
                bus_if.acknowledge = 1'b1;
                bus_if.read_data   = slave_value;
                ack_cyc = cyc;
            end else begin
                bus_if.acknowledge = 1'b0;
                bus_if.read_data   = 16'($urandom);
            end
            wait_cnt++;
        end else begin
            wait_cnt = 0;
            bus_if.acknowledge = idle_noise ? 1'($urandom) : 1'b0;
            bus_if.read_data   = 16'($urandom);
            if (rand_mode) ack_delay = $urandom_range(0, 5);
        end
        if (rand_mode) slave_value = 16'($urandom);
    endtask

    task automatic master_rand();
        for (int n = 0; n < 2; n++) begin
            if (!req[n]) begin
                if ($urandom_range(0, 3) == 0) begin
                    rand_fields(n);
                    req[n] = 1'b1;
                end
            end else if (done_now[n]) begin
                if ($urandom_range(0, 2) != 0) req[n] = 1'b0;
                else rand_fields(n);
            end else if (!grant_now[n] && $urandom_range(0, 19) == 0) begin
                req[n] = 1'b0;
            end else if (!grant_now[n] && $urandom_range(0, 7) == 0) begin
                rand_fields(n);
            end
        end
    endtask

    // One clock: observe at the falling edge, then drive inputs just after.
    task automatic step();
        @(negedge clk_clk);
        cyc++;
        done_now[0] = m0_done;  done_now[1] = m1_done;
        grant_now[0] = m0_grant; grant_now[1] = m1_grant;
        if (bus_if.bus_enable) begin
            be_cycles++;
            if (first_be_cyc < 0) first_be_cyc = cyc;
            mon_addr = bus_if.address; mon_be = bus_if.byte_enable;
            mon_rw = bus_if.rw; mon_wd = bus_if.write_data;
            if (!prev_be) begin
                grant_seq.push_back(m1_grant ? 1 : 0);
                if (seen_tx && cur_gap < min_gap) min_gap = cur_gap;
            end
            seen_tx = 1'b1;
            cur_gap = 0;
        end else begin
            cur_gap++;
        end
        prev_be = bus_if.bus_enable;
        if (m0_done || m1_done) begin
            done_cyc = cyc;
            be_at_done = bus_if.bus_enable;
        end
        if (m0_timeout || m1_timeout) to_cyc = cyc;
        done_cnt[0] += int'(m0_done);    done_cnt[1] += int'(m1_done);
        to_cnt[0]   += int'(m0_timeout); to_cnt[1]   += int'(m1_timeout);
        #1;
        slave_step();
        if (rand_mode) begin
            master_rand();
            if (!reset_reset_n) reset_reset_n = 1'b1;
            else if ($urandom_range(0, 249) == 0) reset_reset_n = 1'b0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (done_now[n] && !hold[n]) req[n] = 1'b0;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // ---------------- scenario sequence ----------------
    initial begin
        for (int n = 0; n < 2; n++) begin
            req[n] = 1'b0; m_addr[n] = '0; m_be[n] = '0; m_rw[n] = 1'b0; m_wd[n] = '0;
        end
        bus_if.acknowledge = 1'b0;
        bus_if.read_data   = '0;
        clear_mon();

        // Reset state
        step();
        cmp_en = 1'b1;
        step();
        check("reset_ctrl",
              {bus_if.bus_enable, bus_if.rw, m1_grant, m0_grant, m1_done, m0_done, m1_timeout, m0_timeout},
              8'h00);
        check("reset_bus", {bus_if.address, bus_if.byte_enable, bus_if.write_data}, 38'h0);
        check("reset_rdata", {m1_read_data, m0_read_data}, 32'h0);
        reset_reset_n = 1'b1;
        run(2);

        // Single write, slave acknowledges in the first bus cycle
        clear_mon();
        issue(0, 20'h20004, 2'b11, 1'b0, 16'h1234);
        ack_delay = 0;
        run(8);
        check("wr_latency", first_be_cyc - issue_cyc, 1);
        check("wr_bus_cycles", be_cycles, 1);
        check("wr_fields", {mon_addr, mon_be, mon_rw, mon_wd}, {20'h20004, 2'b11, 1'b0, 16'h1234});
        check("wr_done_pulses", done_cnt[0], 1);
        check("wr_timeout_pulses", to_cnt[0], 0);
        check("wr_idle_after", be_at_done, 1'b0);
        check("wr_rdata_kept", m0_read_data, 16'h0000);

        // Single read, three wait cycles
        clear_mon();
        issue(1, 20'h40000, 2'b11, 1'b1, 16'h0000);
        ack_delay = 3;
        slave_value = 16'hBEEF;
        run(10);
        check("rd_data", m1_read_data, 16'hBEEF);
        check("rd_done_pulses", done_cnt[1], 1);
        check("rd_timeout_pulses", to_cnt[1], 0);
        check("rd_bus_cycles", be_cycles, 4);
        check("rd_done_after_ack", done_cyc - ack_cyc, 1);

        // Timeout: no acknowledge
        clear_mon();
        issue(0, 20'h00ABC, 2'b01, 1'b1, 16'h0000);
        ack_delay = -1;
        run(10);
        check("to_done_pulses", done_cnt[0], 1);
        check("to_timeout_pulses", to_cnt[0], 1);
        check("to_same_cycle", done_cyc - to_cyc, 0);
        check("to_rdata", m0_read_data, 16'hDEAD);
        check("to_bus_cycles", be_cycles, TMO);
        check("to_bus_idle", bus_if.bus_enable, 1'b0);

        // Acknowledge on the expiry cycle
        clear_mon();
        issue(0, 20'h00100, 2'b10, 1'b1, 16'h0000);
        ack_delay = 3;
        slave_value = 16'hC0DE;
        run(10);
        check("exp_timeout_pulses", to_cnt[0], 0);
        check("exp_done_pulses", done_cnt[0], 1);
        check("exp_rdata", m0_read_data, 16'hC0DE);
        check("exp_bus_cycles", be_cycles, TMO);

        // Zero byte enable is forwarded and completes
        clear_mon();
        issue(1, 20'h12345, 2'b00, 1'b0, 16'h5A5A);
        ack_delay = 1;
        run(8);
        check("be0_fields", {mon_addr, mon_be, mon_rw, mon_wd}, {20'h12345, 2'b00, 1'b0, 16'h5A5A});
        check("be0_done_pulses", done_cnt[1], 1);

        // Tie from reset: both held, grants must alternate
        reset_reset_n = 1'b0;
        issue(0, 20'h11111, 2'b11, 1'b0, 16'h0101);
        issue(1, 20'h22222, 2'b11, 1'b1, 16'h0000);
        hold = '{1'b1, 1'b1};
        ack_delay = 1;
        slave_value = 16'h7777;
        step();
        reset_reset_n = 1'b1;
        clear_mon();
        run(40);
        check("tie_count_ok", grant_seq.size() >= 4, 1'b1);
        if (grant_seq.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("tie_grant%0d", i), grant_seq[i], i % 2);
            end
        end
        check("tie_gap_ok", min_gap >= 1, 1'b1);
        req[0] = 1'b0; req[1] = 1'b0;
        hold = '{1'b0, 1'b0};
        run(6);

        // Reset in the middle of a bus cycle
        clear_mon();
        issue(0, 20'h0F0F0, 2'b11, 1'b1, 16'h0000);
        ack_delay = -1;
        run(2);
        check("mid_bus_active", bus_if.bus_enable, 1'b1);
        reset_reset_n = 1'b0;
        req[0] = 1'b0;
        step();
        check("mid_after_reset", {bus_if.bus_enable, m0_grant, m0_done, m0_timeout}, 4'b0000);
        reset_reset_n = 1'b1;
        run(6);
        check("mid_no_done", done_cnt[0] + to_cnt[0], 0);
        clear_mon();
        issue(1, 20'h00042, 2'b11, 1'b0, 16'hCAFE);
        ack_delay = 0;
        run(8);
        check("mid_m1_done", done_cnt[1], 1);
        check("mid_m1_fields", {mon_addr, mon_wd}, {20'h00042, 16'hCAFE});

        // Randomized traffic with idle acknowledge noise and random resets
        clear_mon();
        rand_mode  = 1'b1;
        idle_noise = 1'b1;
        run(3000);
        rand_mode  = 1'b0;
        idle_noise = 1'b0;
        reset_reset_n = 1'b1;
        req[0] = 1'b0; req[1] = 1'b0;
        ack_delay = 0;
        check("rand_done_seen", (done_cnt[0] + done_cnt[1]) > 50, 1'b1);
        check("rand_timeout_seen", (to_cnt[0] + to_cnt[1]) > 0, 1'b1);
        run(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/external_bus_arbiter.md
EXTERNAL_BUS_ARBITER -- requirements
Module: external_bus_arbiter

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 255: the number of cycles bus_enable is held without acknowledge before the transaction is aborted (range 1-65535).
REQ-002 The module SHALL have port clk_clk  input  1  the single clock; all logic is on its rising edge.
REQ-003 The module SHALL have port reset_reset_n  input  1  synchronous, active-low reset.
REQ-004 The module SHALL have ports mN_request  input  1  transaction request from master N (N=0,1), held until mN_done.
REQ-005 The module SHALL have ports mN_address  input  20, mN_byte_enable  input  2, mN_rw  input  1 (1=read), mN_write_data  input  16  master N transaction fields.
REQ-006 The module SHALL have ports mN_grant  output  1 (transaction of master N in progress), mN_done  output  1 (completion pulse), mN_timeout  output  1 (abort pulse), mN_read_data  output  16 (read result).
REQ-007 The module SHALL have ports address  output  20, bus_enable  output  1, byte_enable  output  2, rw  output  1, write_data  output  16  external bus master side.
REQ-008 The module SHALL have ports acknowledge  input  1 and read_data  input  16  external bus slave response.

Function
REQ-009 The module SHALL implement states IDLE, BUS, TURN; all outputs SHALL be registered.
REQ-010 In IDLE with exactly one request high, the module SHALL grant that master; with both high, the one not granted last; last-granted SHALL reset to master 1 so master 0 wins the first tie.
REQ-011 On grant (IDLE->BUS), the module SHALL latch the winner's address, byte_enable, rw and write_data onto the bus outputs, set bus_enable=1 and mN_grant=1 on the next edge; bus outputs SHALL stay constant through BUS.
REQ-012 A request sampled at edge E SHALL give bus_enable=1 after E (one-cycle request-to-bus latency).
REQ-013 In BUS, acknowledge sampled high SHALL: capture read_data into mN_read_data if rw=1 (leave it unchanged if rw=0), pulse mN_done for exactly one cycle, clear bus_enable and mN_grant, go to TURN.
REQ-014 An acknowledge arriving in the same cycle as timeout expiry SHALL be treated as a normal completion (no timeout pulse).
REQ-015 A cycle counter SHALL clear on entry to BUS and increment each BUS cycle; when TIMEOUT cycles pass without acknowledge, mN_done and mN_timeout SHALL pulse together for one cycle, mN_read_data SHALL load 16'hDEAD on a read, and the FSM SHALL go to TURN.
REQ-016 TURN SHALL last exactly one cycle with bus_enable=0, then return to IDLE; this guarantees at least one idle bus cycle between transactions.
REQ-017 A request still high in IDLE after mN_done SHALL be treated as a new transaction.
REQ-018 Request changes by the non-granted master during BUS/TURN SHALL be ignored until IDLE.
REQ-019 byte_enable=2'b00 SHALL be forwarded unchanged and completed normally.
REQ-020 Acknowledge while IDLE or TURN SHALL be ignored.

Reset
REQ-021 With reset_reset_n=0 at an edge, the FSM SHALL go to IDLE. bus_enable, rw, mN_grant, mN_done and mN_timeout SHALL be 0. address, byte_enable, write_data and mN_read_data SHALL be all-zero. The counter SHALL clear and last-granted SHALL be master 1.
REQ-022 Reset during BUS SHALL abort the transaction with no done or timeout pulse; bus_enable SHALL be 0 after that edge.

Verification
REQ-023 Single write: m0 write, address 20'h20004, byte_enable 2'b11, data 16'h1234, slave acknowledge=bus_enable -> bus_enable high for exactly 1 cycle with those values, m0_done pulses once, then 1 idle bus cycle.
REQ-024 Single read: m1 read, address 20'h40000, slave returns 16'hBEEF on acknowledge after 3 wait cycles -> m1_read_data=16'hBEEF, m1_done one cycle after acknowledge, m1_timeout=0.
REQ-025 Tie: both request together, held continuously, from reset -> grants alternate m0, m1, m0, m1, with bus_enable low between every pair of transactions.
REQ-026 Timeout: TIMEOUT=4, m0 read, acknowledge never asserted -> m0_done and m0_timeout pulse together after 4 BUS cycles, m0_read_data=16'hDEAD, bus returns to idle.
REQ-027 Reset mid-BUS: reset_reset_n low during BUS -> bus_enable and m0_grant low after the edge, no done pulse; after release a new m1 request is serviced normally.
REQ-028 Ack-at-expiry: TIMEOUT=4, acknowledge arrives in the 4th BUS cycle -> done without timeout, read_data captured.
